seed_round_ctrl: RTL and testbench

Sequencer for the byte-serial SEED round datapath. Accepts a block request, drives the 16-byte load phase, and steps the F-function phase counter `main_counter` (0..16) through 16 rounds. It then drains the G/adder pipeline and drives the 16-byte unload phase. It sits between the cipher top-level handshake and the F-function/key-schedule datapath, and is the only source of `main_counter`.

---
 rtl/seed_ctrl_pkg.sv | 23 ++
 rtl/seed_phase_counter.sv | 48 ++++
 rtl/seed_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_seed_round_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_ctrl_pkg.sv
// Shared definitions for the SEED round sequencer: FSM states and block geometry.
package seed_ctrl_pkg;

    localparam int NUM_ROUNDS  = 16;
    localparam int CNT_MAX     = 16;
    localparam int FLUSH_LEN   = 4;
    localparam int BLOCK_BYTES = 16;

    localparam int CNT_W   = 5;
    localparam int ROUND_W = 4;
    localparam int BYTE_W  = 4;
    localparam int FLUSH_W = $clog2(FLUSH_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FLUSH,
        UNLOAD,
        DONE
    } state_t;

endpackage

// File: rtl/seed_phase_counter.sv
// F-function phase counter (main_counter) paired with the round index.
module seed_phase_counter
    import seed_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_step,
    output logic [CNT_W-1:0]   o_main_counter,
    output logic [ROUND_W-1:0] o_round_idx,
    output logic               o_cnt_last,
    output logic               o_round_last
);

    logic [CNT_W-1:0]   r_main_counter;
    logic [ROUND_W-1:0] r_round_idx;
    logic               w_cnt_last;
    logic               w_round_last;

    assign w_cnt_last   = (r_main_counter == CNT_W'(CNT_MAX));
    assign w_round_last = (r_round_idx == ROUND_W'(NUM_ROUNDS - 1));

    // On the last round the phase returns to 0 while round_idx stays at its final value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_main_counter <= '0;
            r_round_idx    <= '0;
        end else if (i_clear) begin
            r_main_counter <= '0;
            r_round_idx    <= '0;
        end else if (i_step) begin
            if (w_cnt_last) begin
                r_main_counter <= '0;
                if (!w_round_last) begin
                    r_round_idx <= r_round_idx + ROUND_W'(1);
                end
            end else begin
                r_main_counter <= r_main_counter + CNT_W'(1);
            end
        end
    end

    assign o_main_counter = r_main_counter;
    assign o_round_idx    = r_round_idx;
    assign o_cnt_last     = w_cnt_last;
    assign o_round_last   = w_round_last;

endmodule

// File: rtl/seed_round_ctrl.sv
// Byte-serial SEED round sequencer: load, 16 rounds of F phases, flush, unload, done.
module seed_round_ctrl
    import seed_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_decrypt,
    input  logic               i_stall,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_load_en,
    output logic [BYTE_W-1:0]  o_load_idx,
    output logic [CNT_W-1:0]   o_main_counter,
    output logic [ROUND_W-1:0] o_round_idx,
    output logic [ROUND_W-1:0] o_key_idx,
    output logic               o_key_req,
    output logic               o_swap_en,
    output logic               o_out_valid,
    output logic [BYTE_W-1:0]  o_out_idx,
    output logic               o_done,
    output state_t             o_state
);

    state_t               r_state;
    state_t               w_next;
    logic                 r_decrypt;
    logic [BYTE_W-1:0]    r_load_idx;
    logic [BYTE_W-1:0]    r_out_idx;
    logic [FLUSH_W-1:0]   r_flush_cnt;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_load_en;
    logic                 w_key_req;
    logic                 w_swap_en;
    logic                 w_out_valid;
    logic                 w_done;
    logic [CNT_W-1:0]     w_main_counter;
    logic [ROUND_W-1:0]   w_round_idx;
    logic                 w_cnt_last;
    logic                 w_round_last;
    logic                 w_load_last;
    logic                 w_out_last;
    logic                 w_flush_last;

    // start is taken in any cycle where ready is high (stall is ignored in IDLE); nothing is queued.
    assign w_accept     = (r_state == IDLE) && i_start;
    assign w_step       = (r_state == RUN) && !i_stall;
    assign w_load_last  = (r_load_idx == BYTE_W'(BLOCK_BYTES - 1));
    assign w_out_last   = (r_out_idx == BYTE_W'(BLOCK_BYTES - 1));
    assign w_flush_last = (r_flush_cnt == FLUSH_W'(FLUSH_LEN - 1));

    seed_phase_counter u_phase (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_clear        (w_accept),
        .i_step         (w_step),
        .o_main_counter (w_main_counter),
        .o_round_idx    (w_round_idx),
        .o_cnt_last     (w_cnt_last),
        .o_round_last   (w_round_last)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load_en   = 1'b0;
        w_key_req   = 1'b0;
        w_swap_en   = 1'b0;
        w_out_valid = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_next = LOAD;
            end
            LOAD: begin
                if (!i_stall) begin
                    w_load_en = 1'b1;
                    if (w_load_last) w_next = RUN;
                end
            end
            RUN: begin
                if (!i_stall) begin
                    w_key_req = (w_main_counter == '0);
                    w_swap_en = w_cnt_last && !w_round_last;
                    if (w_cnt_last && w_round_last) w_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!i_stall && w_flush_last) w_next = UNLOAD;
            end
            UNLOAD: begin
                if (!i_stall) begin
                    w_out_valid = 1'b1;
                    if (w_out_last) w_next = DONE;
                end
            end
            DONE: begin
                if (!i_stall) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_decrypt   <= 1'b0;
            r_load_idx  <= '0;
            r_out_idx   <= '0;
            r_flush_cnt <= '0;
        end else if (w_accept) begin
            r_decrypt   <= i_decrypt;
            r_load_idx  <= '0;
            r_out_idx   <= '0;
            r_flush_cnt <= '0;
        end else if (!i_stall) begin
            if (r_state == LOAD && !w_load_last) begin
                r_load_idx <= r_load_idx + BYTE_W'(1);
            end
            if (r_state == FLUSH) begin
                r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + FLUSH_W'(1);
            end
            if (r_state == UNLOAD && !w_out_last) begin
                r_out_idx <= r_out_idx + BYTE_W'(1);
            end
        end
    end

    assign o_ready        = (r_state == IDLE);
    assign o_busy         = (r_state == LOAD) || (r_state == RUN) ||
                            (r_state == FLUSH) || (r_state == UNLOAD);
    assign o_load_en      = w_load_en;
    assign o_load_idx     = r_load_idx;
    assign o_main_counter = w_main_counter;
    assign o_round_idx    = w_round_idx;
    assign o_key_idx      = r_decrypt ? (ROUND_W'(NUM_ROUNDS - 1) - w_round_idx) : w_round_idx;
    assign o_key_req      = w_key_req;
    assign o_swap_en      = w_swap_en;
    assign o_out_valid    = w_out_valid;
    assign o_out_idx      = r_out_idx;
    assign o_done         = w_done;
    assign o_state        = r_state;

endmodule

// File: tb/tb_seed_round_ctrl.sv
// Bench for seed_round_ctrl: a cycle-offset timeline model drives per-cycle expectations.
module tb_seed_round_ctrl;
    import seed_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         decrypt = 1'b0;
    logic         stall = 1'b0;
    logic         o_ready, o_busy, o_load_en, o_key_req, o_swap_en, o_out_valid, o_done;
    logic [3:0]   o_load_idx, o_round_idx, o_key_idx, o_out_idx;
    logic [4:0]   o_main_counter;
    state_t       o_state;

    seed_round_ctrl dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_decrypt      (decrypt),
        .i_stall        (stall),
        .o_ready        (o_ready),
        .o_busy         (o_busy),
        .o_load_en      (o_load_en),
        .o_load_idx     (o_load_idx),
        .o_main_counter (o_main_counter),
        .o_round_idx    (o_round_idx),
        .o_key_idx      (o_key_idx),
        .o_key_req      (o_key_req),
        .o_swap_en      (o_swap_en),
        .o_out_valid    (o_out_valid),
        .o_out_idx      (o_out_idx),
        .o_done         (o_done),
        .o_state        (o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // A block is a timeline of unstalled cycles: offset 1..16 load, 17..288 rounds,
    // 289..292 flush, 293..308 unload, 309 done. Stalled cycles do not advance it.
    int         checks = 0;
    int         errors = 0;
    bit         m_in_blk = 1'b0;
    int         m_p = 0;
    bit         m_dec = 1'b0;
    bit         m_fresh = 1'b1;
    int         m_done_events = 0;
    int         cyc = 0;
    int         accept_cyc = 0;

    int         done_count, last_done_off, keyreq_count, swap_count, load_count, outv_count;
    logic [3:0] obs_key_q[$];
    logic [3:0] exp_q[$];
    int         done_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        done_count    = 0;
        last_done_off = -1;
        keyreq_count  = 0;
        swap_count    = 0;
        load_count    = 0;
        outv_count    = 0;
        obs_key_q.delete();
        exp_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic check_outputs();
        state_t es;
        logic   e_ready, e_busy, e_load, e_key, e_swap, e_outv, e_done;
        int     e_main, q, r, m;
        logic   sl;
        sl = stall;
        es = IDLE;
        e_ready = !m_in_blk;
        e_busy = 1'b0; e_load = 1'b0; e_key = 1'b0; e_swap = 1'b0;
        e_outv = 1'b0; e_done = 1'b0; e_main = 0;
        if (m_in_blk) begin
            e_busy = (m_p <= 308);
            if (m_p <= 16) begin
                es = LOAD;
                e_load = !sl;
                chk("load_idx", o_load_idx, m_p - 1);
            end else if (m_p <= 288) begin
                es = RUN;
                q = m_p - 17;
                r = q / 17;
                m = q % 17;
                e_main = m;
                e_key  = (m == 0) && !sl;
                e_swap = (m == 16) && (r < 15) && !sl;
                chk("round_idx", o_round_idx, r);
                chk("key_idx", o_key_idx, m_dec ? 15 - r : r);
            end else if (m_p <= 292) begin
                es = FLUSH;
                chk("round_idx_flush", o_round_idx, 15);
            end else if (m_p <= 308) begin
                es = UNLOAD;
                e_outv = !sl;
                chk("out_idx", o_out_idx, m_p - 293);
                chk("round_idx_unload", o_round_idx, 15);
            end else begin
                es = DONE;
                e_done = !sl;
            end
        end else if (m_fresh) begin
            chk("load_idx_rst", o_load_idx, 0);
            chk("out_idx_rst", o_out_idx, 0);
            chk("round_idx_rst", o_round_idx, 0);
            chk("key_idx_rst", o_key_idx, 0);
        end
        chk("state", o_state, es);
        chk("ready", o_ready, e_ready);
        chk("busy", o_busy, e_busy);
        chk("load_en", o_load_en, e_load);
        chk("main_counter", o_main_counter, e_main);
        chk("key_req", o_key_req, e_key);
        chk("swap_en", o_swap_en, e_swap);
        chk("out_valid", o_out_valid, e_outv);
        chk("done", o_done, e_done);
        if (o_done === 1'b1) begin
            done_count++;
            last_done_off = cyc - accept_cyc;
            done_cyc_q.push_back(cyc);
        end
        if (o_key_req === 1'b1) begin
            keyreq_count++;
            obs_key_q.push_back(o_key_idx);
        end
        if (o_swap_en === 1'b1) swap_count++;
        if (o_load_en === 1'b1) load_count++;
        if (o_out_valid === 1'b1) outv_count++;
    endtask

    task automatic model_edge(input bit st, input bit sl, input bit dec);
        if (!m_in_blk) begin
            if (st) begin
                m_in_blk = 1'b1;
                m_p = 1;
                m_dec = dec;
                m_fresh = 1'b0;
                accept_cyc = cyc;
            end
        end else if (!sl) begin
            if (m_p == 309) begin
                m_in_blk = 1'b0;
                m_done_events++;
            end else begin
                m_p++;
            end
        end
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    // Entered just after a rising edge: drive, settle, check, then cross the next edge.
    task automatic tick(input bit st, input bit sl, input bit dec);
        start = st;
        stall = sl;
        decrypt = dec;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(st, sl, dec);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        m_in_blk = 1'b0;
        m_fresh = 1'b1;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        reset = 1'b0;
    endtask

    task automatic run_block(input bit dec, input int stall_p, input int stall_n, input bit noise);
        int sc;
        bit sl, st;
        sc = 0;
        clear_stats();
        tick(1'b1, 1'b0, dec);
        for (int i = 0; i < 1000 && m_in_blk; i++) begin
            sl = 1'b0;
            st = 1'b0;
            if (m_p == stall_p && sc < stall_n) begin
                sl = 1'b1;
                sc++;
            end
            if (noise && (m_p == 5 || m_p == 100 || m_p == 200)) st = 1'b1;
            tick(st, sl, 1'($urandom_range(0, 1)));
        end
        tick(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        do_reset();
        tick(1'b0, 1'b0, 1'b0);

        // Plain encrypt block
        run_block(1'b0, -1, 0, 1'b0);
        chk("enc_done_count", done_count, 1);
        chk("enc_done_offset", last_done_off, 309);
        chk("enc_load_count", load_count, 16);
        chk("enc_keyreq_count", keyreq_count, 16);
        chk("enc_swap_count", swap_count, 15);
        chk("enc_outv_count", outv_count, 16);
        for (int k = 0; k < 16; k++) exp_q.push_back(4'(k));
        chk("enc_keyq_size", obs_key_q.size(), 16);
        while (exp_q.size() > 0 && obs_key_q.size() > 0)
            chk("enc_key_seq", obs_key_q.pop_front(), exp_q.pop_front());

        // Decrypt block: key indices run 15 down to 0
        run_block(1'b1, -1, 0, 1'b0);
        chk("dec_done_offset", last_done_off, 309);
        for (int k = 15; k >= 0; k--) exp_q.push_back(4'(k));
        chk("dec_keyq_size", obs_key_q.size(), 16);
        while (exp_q.size() > 0 && obs_key_q.size() > 0)
            chk("dec_key_seq", obs_key_q.pop_front(), exp_q.pop_front());

        // Five-cycle stall at main_counter=16, round_idx=3
        run_block(1'b0, 17 + 3 * 17 + 16, 5, 1'b0);
        chk("stall_done_offset", last_done_off, 314);
        chk("stall_swap_count", swap_count, 15);
        chk("stall_keyreq_count", keyreq_count, 16);

        // Stray start pulses during LOAD and RUN
        run_block(1'b0, -1, 0, 1'b1);
        chk("noise_done_count", done_count, 1);
        chk("noise_done_offset", last_done_off, 309);

        // Reset mid-RUN at round 7 aborts; a fresh block then runs in full
        clear_stats();
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 400 && m_in_blk && m_p != 17 + 7 * 17 + 5; i++)
            tick(1'b0, 1'b0, 1'b0);
        chk("abort_round_idx", o_round_idx, 7);
        do_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        chk("abort_no_done", done_count, 0);
        run_block(1'b0, -1, 0, 1'b0);
        chk("post_abort_done_offset", last_done_off, 309);

        // Back-to-back with start held high
        clear_stats();
        t0 = cyc;
        for (int i = 0; i < 625; i++) tick(1'b1, 1'b0, 1'b0);
        chk("b2b_done_count", done_count, 2);
        if (done_cyc_q.size() >= 2) begin
            chk("b2b_done0", done_cyc_q[0] - t0, 309);
            chk("b2b_done1", done_cyc_q[1] - t0, 619);
        end
        for (int i = 0; i < 400 && m_in_blk; i++) tick(1'b0, 1'b0, 1'b0);

        // Random start/stall/decrypt traffic
        clear_stats();
        m_done_events = 0;
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 800 && m_in_blk; i++)
            tick(1'b0, 1'($urandom_range(0, 7) == 0), 1'b0);
        chk("rand_done_count", done_count, m_done_events);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
